nor_maj_cone_pipe: RTL

Parametrised, pipelined successor to the two-input NOR-equivalent timing cone. It applies a selectable inverting logic function to WIDTH lanes: NOR, NAND, inverted majority or OAI21. Operands and opcode travel together through STAGES register stages under a valid/ready handshake. It sits between synthetic cone generators and downstream timing-cone consumers, and gives realistic register-to-register paths around the ASAP7 inverting primitives.

---
 rtl/nor_maj_cone_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/nor_maj_cone_pipe.sv
// Pipelined inverting-function cone (NOR / NAND / inverted majority / OAI21) over WIDTH lanes
// with a STAGES-deep valid/ready pipeline. Define CONE_STATS_EN to add the out_count result counter.
module nor_maj_cone_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [1:0]       out_op
`ifdef CONE_STATS_EN
    ,
    output logic [15:0]      out_count
`endif
);

    logic [WIDTH-1:0] func_y;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : lane_g
        logic lane_y;

        always_comb begin
            lane_y = 1'b0;
            case (in_op)
                2'b00:   lane_y = ~(in_a[gi] | in_b[gi]);
                2'b01:   lane_y = ~(in_a[gi] & in_b[gi]);
                2'b10:   lane_y = ~((in_a[gi] & in_b[gi]) | (in_a[gi] & in_c[gi]) | (in_b[gi] & in_c[gi]));
                default: lane_y = ~((in_a[gi] | in_b[gi]) & in_c[gi]);
            endcase
        end

        assign func_y[gi] = lane_y;
    end

    logic [STAGES-1:0] valid_vec;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  y_vec  [STAGES];
    logic [1:0]        op_vec [STAGES];

    // A stage may load if it is empty or everything downstream of it can move;
    // this ripples combinationally from out_ready back to in_ready.
    always_comb begin : load_chain
        logic ready_acc;
        ready_acc = out_ready;
        load      = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ready_acc = !valid_vec[i] || ready_acc;
            load[i]   = ready_acc;
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : stage_g
        logic             valid_reg;
        logic [WIDTH-1:0] y_reg;
        logic [1:0]       op_reg;
        logic             src_valid;
        logic [WIDTH-1:0] src_y;
        logic [1:0]       src_op;

        if (gi == 0) begin : g_src
            assign src_valid = in_valid;
            assign src_y     = func_y;
            assign src_op    = in_op;
        end else begin : g_src
            assign src_valid = valid_vec[gi-1];
            assign src_y     = y_vec[gi-1];
            assign src_op    = op_vec[gi-1];
        end

        // Data only captured with a valid token so bubbles do not disturb held values.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
                y_reg     <= '0;
                op_reg    <= '0;
            end else if (load[gi]) begin
                valid_reg <= src_valid;
                if (src_valid) begin
                    y_reg  <= src_y;
                    op_reg <= src_op;
                end
            end
        end

        assign valid_vec[gi] = valid_reg;
        assign y_vec[gi]     = y_reg;
        assign op_vec[gi]    = op_reg;
    end

    assign in_ready  = load[0];
    assign out_valid = valid_vec[STAGES-1];
    assign out_y     = y_vec[STAGES-1];
    assign out_op    = op_vec[STAGES-1];

`ifdef CONE_STATS_EN
    logic [15:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (out_valid && out_ready && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign out_count = count_reg;
`endif

endmodule
